riscv_dbus_fabric: RTL and testbench

Parametrised data-side interconnect between the pipelined core's data port and NUM_REGIONS memory-mapped slaves (data memory, MMIO peripherals). It replaces the fixed single-data-memory hookup with an address-decoded, handshaked, one-outstanding-transaction bus. Slaves may insert arbitrary wait states. Unmapped or (optionally) timed-out accesses return an error response instead of hanging the core.

---
 rtl/riscv_dbus_fabric.sv | 214 +++++++++++++++++++++
 tb/tb_riscv_dbus_fabric.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dbus_fabric.sv
// rtl/riscv_dbus_fabric.sv - address-decoded, one-outstanding data bus fabric for the core's data port
//
// Purpose:
//   Routes a single master data request to one of NUM_REGIONS slaves chosen
//   by (addr & mask_i) == base_i, lowest index winning on overlap. Slaves may
//   stall with s_ack low. Unmapped addresses return an error response.
//
// Optional feature macro: DBUS_TIMEOUT_EN
//   When defined, an access that sees no ack for TIMEOUT_CYCLES cycles is
//   abandoned and answered with m_err=1. When undefined, no counter exists
//   and ACCESS waits indefinitely.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   m_req/m_addr/m_wdata/m_we/m_be   master request, held until m_ready
//   m_ready/m_rdata/m_err            one-cycle response pulse with data/error
//   s_req             one-hot slave request (high only during ACCESS)
//   s_addr/s_wdata/s_we/s_be         registered payload shared by all slaves
//   s_rdata/s_ack     per-slave read data (flattened) and completion

module riscv_dbus_fabric #(
  parameter int unsigned                 NUM_REGIONS    = 2,
  parameter logic [NUM_REGIONS*32-1:0]   REGION_BASE    = {32'h00001000, 32'h00000000},
  parameter logic [NUM_REGIONS*32-1:0]   REGION_MASK    = {32'hFFFFF000, 32'hFFFFF000},
  parameter int unsigned                 TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        m_req,
  input  logic [31:0]                 m_addr,
  input  logic [31:0]                 m_wdata,
  input  logic                        m_we,
  input  logic [3:0]                  m_be,
  output logic                        m_ready,
  output logic [31:0]                 m_rdata,
  output logic                        m_err,
  output logic [NUM_REGIONS-1:0]      s_req,
  output logic [31:0]                 s_addr,
  output logic [31:0]                 s_wdata,
  output logic                        s_we,
  output logic [3:0]                  s_be,
  input  logic [NUM_REGIONS*32-1:0]   s_rdata,
  input  logic [NUM_REGIONS-1:0]      s_ack
);

  if (NUM_REGIONS < 1 || NUM_REGIONS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("riscv_dbus_fabric: NUM_REGIONS must be 1..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                   state_q,   state_d;
  logic                     m_ready_q, m_ready_d;
  logic [31:0]              m_rdata_q, m_rdata_d;
  logic                     m_err_q,   m_err_d;
  logic [NUM_REGIONS-1:0]   s_req_q,   s_req_d;
  logic [31:0]              s_addr_q,  s_addr_d;
  logic [31:0]              s_wdata_q, s_wdata_d;
  logic                     s_we_q,    s_we_d;
  logic [3:0]               s_be_q,    s_be_d;

  // Address decode: first matching region claims the access.
  logic [NUM_REGIONS-1:0]   hit_oh;
  logic                     hit_any;

  always_comb begin
    hit_oh  = '0;
    hit_any = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!hit_any && ((m_addr & REGION_MASK[32*i +: 32]) == REGION_BASE[32*i +: 32])) begin
        hit_oh[i] = 1'b1;
        hit_any   = 1'b1;
      end
    end
  end

  // s_req_q doubles as the registered one-hot region select, so acks and
  // read data from non-selected slaves are masked out here.
  logic        sel_ack;
  logic [31:0] sel_rdata;

  always_comb begin
    sel_ack   = |(s_ack & s_req_q);
    sel_rdata = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (s_req_q[i]) begin
        sel_rdata = sel_rdata | s_rdata[32*i +: 32];
      end
    end
  end

  logic tmo_hit;

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts un-acked ACCESS cycles; zero everywhere else so each access starts fresh.
  always_comb begin
    tmo_d = '0;
    if (state_q == ACCESS && !sel_ack) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign tmo_hit = (state_q == ACCESS) && (tmo_q == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    m_ready_d = 1'b0;
    m_rdata_d = m_rdata_q;
    m_err_d   = m_err_q;
    s_req_d   = s_req_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_we_d    = s_we_q;
    s_be_d    = s_be_q;

    case (state_q)
      IDLE: begin
        if (m_req) begin
          if (hit_any) begin
            state_d   = ACCESS;
            s_req_d   = hit_oh;
            s_addr_d  = m_addr;
            s_wdata_d = m_wdata;
            s_we_d    = m_we;
            s_be_d    = m_be;
          end else begin
            state_d   = RESP;
            m_ready_d = 1'b1;
            m_err_d   = 1'b1;
            m_rdata_d = '0;
          end
        end
      end
      ACCESS: begin
        // A real ack takes priority over a timeout landing on the same cycle.
        if (sel_ack) begin
          state_d   = RESP;
          s_req_d   = '0;
          m_ready_d = 1'b1;
          m_err_d   = 1'b0;
          m_rdata_d = s_we_q ? 32'h0 : sel_rdata;
        end else if (tmo_hit) begin
          state_d   = RESP;
          s_req_d   = '0;
          m_ready_d = 1'b1;
          m_err_d   = 1'b1;
          m_rdata_d = '0;
        end
      end
      RESP: begin
        // m_ready_q is high for this one cycle; a still-high m_req is not sampled.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        s_req_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_ready_q <= 1'b0;
      m_rdata_q <= '0;
      m_err_q   <= 1'b0;
      s_req_q   <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_we_q    <= 1'b0;
      s_be_q    <= '0;
    end else begin
      state_q   <= state_d;
      m_ready_q <= m_ready_d;
      m_rdata_q <= m_rdata_d;
      m_err_q   <= m_err_d;
      s_req_q   <= s_req_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_we_q    <= s_we_d;
      s_be_q    <= s_be_d;
    end
  end

  assign m_ready = m_ready_q;
  assign m_rdata = m_rdata_q;
  assign m_err   = m_err_q;
  assign s_req   = s_req_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_we    = s_we_q;
  assign s_be    = s_be_q;

endmodule

// File: tb/tb_riscv_dbus_fabric.sv
// tb/tb_riscv_dbus_fabric.sv - directed self-checking bench for riscv_dbus_fabric

module tb_riscv_dbus_fabric;

  logic        clk;
  logic        rst_n;
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic [3:0]  m_be;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        m_err;
  logic [1:0]  s_req;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_we;
  logic [3:0]  s_be;
  logic [63:0] s_rdata;
  logic [1:0]  s_ack;

  // Second instance with overlapping regions
  logic        o_m_req;
  logic [31:0] o_m_addr;
  logic        o_m_ready;
  logic [31:0] o_m_rdata;
  logic        o_m_err;
  logic [1:0]  o_s_req;
  logic [31:0] o_s_addr;
  logic [31:0] o_s_wdata;
  logic        o_s_we;
  logic [3:0]  o_s_be;
  logic [63:0] o_s_rdata;
  logic [1:0]  o_s_ack;

  // Slave model controls
  logic [1:0]  sl_en;
  int          wait_n [2];
  int          wcnt   [2];
  logic        spur_ack0;

  int n_checks;
  int n_pass;

  riscv_dbus_fabric u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_req   (m_req),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_we    (m_we),
    .m_be    (m_be),
    .m_ready (m_ready),
    .m_rdata (m_rdata),
    .m_err   (m_err),
    .s_req   (s_req),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_we    (s_we),
    .s_be    (s_be),
    .s_rdata (s_rdata),
    .s_ack   (s_ack)
  );

  riscv_dbus_fabric #(
    .NUM_REGIONS (2),
    .REGION_BASE ({32'h00000000, 32'h00000000}),
    .REGION_MASK ({32'hFFFF0000, 32'hFFFF0000})
  ) u_dut_ovl (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_req   (o_m_req),
    .m_addr  (o_m_addr),
    .m_wdata (32'h0),
    .m_we    (1'b0),
    .m_be    (4'hF),
    .m_ready (o_m_ready),
    .m_rdata (o_m_rdata),
    .m_err   (o_m_err),
    .s_req   (o_s_req),
    .s_addr  (o_s_addr),
    .s_wdata (o_s_wdata),
    .s_we    (o_s_we),
    .s_be    (o_s_be),
    .s_rdata (o_s_rdata),
    .s_ack   (o_s_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    s_ack[0] = (s_req[0] && sl_en[0] && (wcnt[0] >= wait_n[0])) || spur_ack0;
    s_ack[1] =  s_req[1] && sl_en[1] && (wcnt[1] >= wait_n[1]);
  end

  always @(posedge clk) begin
    wcnt[0] <= s_req[0] ? wcnt[0] + 1 : 0;
    wcnt[1] <= s_req[1] ? wcnt[1] + 1 : 0;
  end

  assign o_s_ack   = o_s_req;
  assign o_s_rdata = {32'h22222222, 32'h11111111};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic we, input logic [3:0] be);
    m_req   = 1'b1;
    m_addr  = addr;
    m_wdata = wdata;
    m_we    = we;
    m_be    = be;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_ready"}, {31'h0, m_ready}, 32'h0);
    check({tag, "_m_rdata"}, m_rdata, 32'h0);
    check({tag, "_m_err"},   {31'h0, m_err},   32'h0);
    check({tag, "_s_req"},   {30'h0, s_req},   32'h0);
    check({tag, "_s_addr"},  s_addr,  32'h0);
    check({tag, "_s_wdata"}, s_wdata, 32'h0);
    check({tag, "_s_we"},    {31'h0, s_we},    32'h0);
    check({tag, "_s_be"},    {28'h0, s_be},    32'h0);
  endtask

  task automatic read_r1_cafe(input string tag);
    sl_en[1]         = 1'b1;
    wait_n[1]        = 0;
    s_rdata[63:32]   = 32'hCAFEF00D;
    issue(32'h00001004, 32'h0, 1'b0, 4'hF);
    tick();
    check({tag, "_c1_s_req"},   {30'h0, s_req}, 32'h2);
    check({tag, "_c1_m_ready"}, {31'h0, m_ready}, 32'h0);
    check({tag, "_c1_s_addr"},  s_addr, 32'h00001004);
    tick();
    m_req = 1'b0;
    check({tag, "_c2_m_ready"}, {31'h0, m_ready}, 32'h1);
    check({tag, "_c2_m_rdata"}, m_rdata, 32'hCAFEF00D);
    check({tag, "_c2_m_err"},   {31'h0, m_err}, 32'h0);
    check({tag, "_c2_s_req"},   {30'h0, s_req}, 32'h0);
    tick();
    check({tag, "_c3_m_ready"}, {31'h0, m_ready}, 32'h0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    m_req     = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_we      = 1'b0;
    m_be      = '0;
    o_m_req   = 1'b0;
    o_m_addr  = '0;
    s_rdata   = '0;
    sl_en     = 2'b11;
    wait_n[0] = 0;
    wait_n[1] = 0;
    spur_ack0 = 1'b0;

    tick();
    tick();
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Read region 1, zero-wait combinational ack
    read_r1_cafe("rd1");

    // Write region 0 with 3 wait cycles
    wait_n[0]      = 3;
    s_rdata[31:0]  = 32'hDEADBEEF;
    issue(32'h00000010, 32'h12345678, 1'b1, 4'b0011);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("wr_c%0d_s_req", c),   {30'h0, s_req}, 32'h1);
      check($sformatf("wr_c%0d_s_addr", c),  s_addr,  32'h00000010);
      check($sformatf("wr_c%0d_s_wdata", c), s_wdata, 32'h12345678);
      check($sformatf("wr_c%0d_s_be", c),    {28'h0, s_be}, 32'h3);
      check($sformatf("wr_c%0d_m_ready", c), {31'h0, m_ready}, 32'h0);
    end
    check("wr_s_we", {31'h0, s_we}, 32'h1);
    tick();
    m_req = 1'b0;
    check("wr_c5_m_ready", {31'h0, m_ready}, 32'h1);
    check("wr_c5_m_err",   {31'h0, m_err},   32'h0);
    check("wr_c5_m_rdata", m_rdata, 32'h0);
    tick();
    wait_n[0] = 0;

    // Unmapped access
    issue(32'h80000000, 32'h0, 1'b0, 4'hF);
    tick();
    check("unm_c1_m_ready", {31'h0, m_ready}, 32'h1);
    check("unm_c1_m_err",   {31'h0, m_err},   32'h1);
    check("unm_c1_m_rdata", m_rdata, 32'h0);
    check("unm_c1_s_req",   {30'h0, s_req},   32'h0);
    check("unm_c1_s_addr_hold", s_addr, 32'h00000010);
    m_req = 1'b0;
    tick();
    check("unm_c2_m_ready", {31'h0, m_ready}, 32'h0);

    // Slave 1 never acks
    sl_en[1] = 1'b0;
    issue(32'h00001000, 32'h0, 1'b0, 4'hF);
`ifdef DBUS_TIMEOUT_EN
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 1 || c == 16) begin
        check($sformatf("tmo_c%0d_s_req", c),   {30'h0, s_req}, 32'h2);
        check($sformatf("tmo_c%0d_m_ready", c), {31'h0, m_ready}, 32'h0);
      end
    end
    tick();
    m_req = 1'b0;
    check("tmo_c17_m_ready", {31'h0, m_ready}, 32'h1);
    check("tmo_c17_m_err",   {31'h0, m_err},   32'h1);
    check("tmo_c17_m_rdata", m_rdata, 32'h0);
    check("tmo_c17_s_req",   {30'h0, s_req},   32'h0);
    tick();
`else
    for (int c = 1; c <= 100; c++) begin
      tick();
    end
    m_req = 1'b0;
    check("notmo_c100_s_req",   {30'h0, s_req},   32'h2);
    check("notmo_c100_m_ready", {31'h0, m_ready}, 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("notmo_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
`endif

    // Spurious ack on region 0 during a region-1 access, then async reset mid-ACCESS
    issue(32'h00001008, 32'hA5A5A5A5, 1'b1, 4'hF);
    tick();
    spur_ack0 = 1'b1;
    tick();
    check("spur_s_req",   {30'h0, s_req},   32'h2);
    check("spur_m_ready", {31'h0, m_ready}, 32'h0);
    tick();
    check("spur2_m_ready", {31'h0, m_ready}, 32'h0);
    #2;
    rst_n = 1'b0;
    m_req = 1'b0;
    #1;
    check_all_zero("midrst");
    spur_ack0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("postrst_m_ready", {31'h0, m_ready}, 32'h0);

    // Recovery after reset
    read_r1_cafe("rec");

    // Overlapping regions: lowest index wins
    o_m_req  = 1'b1;
    o_m_addr = 32'h00000100;
    tick();
    check("ovl_c1_s_req", {30'h0, o_s_req}, 32'h1);
    tick();
    o_m_req = 1'b0;
    check("ovl_c2_m_ready", {31'h0, o_m_ready}, 32'h1);
    check("ovl_c2_m_rdata", o_m_rdata, 32'h11111111);
    check("ovl_c2_m_err",   {31'h0, o_m_err},   32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
